// File: rtl/bpu_update_queue.sv
// In-order queue of branch predictions awaiting resolution; pops the oldest entry
// into a registered PHT update. Optional stats counters via BPU_UPDQ_STATS_EN.
module bpu_update_queue #(
  parameter int unsigned ADDR_WIDTH = 9,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned PTR_WIDTH  = 3
) (
  input  logic                  in_Clk,
  input  logic                  in_Rst,
  input  logic                  in_pred_valid,
  input  logic [ADDR_WIDTH-1:0] in_pred_addr,
  input  logic                  in_pred_taken,
  output logic                  out_full,
  output logic                  out_empty,
  output logic [PTR_WIDTH:0]    out_count,
  input  logic                  in_res_valid,
  input  logic                  in_res_taken,
  output logic                  out_upd_valid,
  output logic [ADDR_WIDTH-1:0] out_upd_addr,
  output logic                  out_upd_taken,
  output logic                  out_mispredict,
  output logic                  out_res_err,
  input  logic                  in_flush
`ifdef BPU_UPDQ_STATS_EN
  ,
  output logic [31:0]           out_stat_resolved,
  output logic [31:0]           out_stat_mispred
`endif
);

  logic [ADDR_WIDTH-1:0] mem_addr  [DEPTH];
  logic                  mem_taken [DEPTH];

  logic [PTR_WIDTH-1:0]  wr_q, wr_d, rd_q, rd_d;
  logic [PTR_WIDTH:0]    count_q, count_d;
  logic                  upd_valid_q, upd_taken_q, mispred_q, res_err_q;
  logic [ADDR_WIDTH-1:0] upd_addr_q, upd_addr_d;
  logic                  upd_taken_d;

  logic res_ok, res_err, mispred, push_ok, squash;

  assign out_full  = (count_q == (PTR_WIDTH+1)'(DEPTH));
  assign out_empty = (count_q == '0);

  always_comb begin
    res_ok  = in_res_valid && !out_empty;
    res_err = in_res_valid && out_empty;
    mispred = res_ok && (mem_taken[rd_q] != in_res_taken);
    squash  = mispred || in_flush;
    // A pop in the same edge frees a slot, so a push against a full queue is legal then.
    push_ok = in_pred_valid && (!out_full || res_ok) && !squash;
    rd_d    = rd_q + (res_ok ? PTR_WIDTH'(1) : '0);
    if (squash) begin
      wr_d    = rd_d;
      count_d = '0;
    end else begin
      wr_d    = wr_q + (push_ok ? PTR_WIDTH'(1) : '0);
      count_d = count_q + (push_ok ? (PTR_WIDTH+1)'(1) : '0)
                        - (res_ok  ? (PTR_WIDTH+1)'(1) : '0);
    end
    upd_addr_d  = res_ok ? mem_addr[rd_q] : upd_addr_q;
    upd_taken_d = res_ok ? in_res_taken   : upd_taken_q;
  end

  always_ff @(posedge in_Clk) begin
    if (push_ok) begin
      mem_addr[wr_q]  <= in_pred_addr;
      mem_taken[wr_q] <= in_pred_taken;
    end
  end

  always_ff @(posedge in_Clk or posedge in_Rst) begin
    if (in_Rst) begin
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      upd_valid_q <= 1'b0;
      upd_addr_q  <= '0;
      upd_taken_q <= 1'b0;
      mispred_q   <= 1'b0;
      res_err_q   <= 1'b0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
      upd_valid_q <= res_ok;
      upd_addr_q  <= upd_addr_d;
      upd_taken_q <= upd_taken_d;
      mispred_q   <= mispred;
      res_err_q   <= res_err;
    end
  end

  assign out_count      = count_q;
  assign out_upd_valid  = upd_valid_q;
  assign out_upd_addr   = upd_addr_q;
  assign out_upd_taken  = upd_taken_q;
  assign out_mispredict = mispred_q;
  assign out_res_err    = res_err_q;

`ifdef BPU_UPDQ_STATS_EN
  logic [31:0] stat_res_q, stat_mis_q;

  always_ff @(posedge in_Clk or posedge in_Rst) begin
    if (in_Rst) begin
      stat_res_q <= '0;
      stat_mis_q <= '0;
    end else begin
      if (res_ok && (stat_res_q != '1)) stat_res_q <= stat_res_q + 32'd1;
      if (mispred && (stat_mis_q != '1)) stat_mis_q <= stat_mis_q + 32'd1;
    end
  end

  assign out_stat_resolved = stat_res_q;
  assign out_stat_mispred  = stat_mis_q;
`endif

endmodule

// File: tb/tb_bpu_update_queue.sv
// Directed bench for bpu_update_queue: push/resolve/squash/flush/async-reset scenarios.
module tb_bpu_update_queue;

  logic       in_Clk = 1'b0;
  logic       in_Rst;
  logic       in_pred_valid = 1'b0;
  logic [8:0] in_pred_addr  = '0;
  logic       in_pred_taken = 1'b0;
  logic       out_full, out_empty;
  logic [3:0] out_count;
  logic       in_res_valid = 1'b0;
  logic       in_res_taken = 1'b0;
  logic       out_upd_valid;
  logic [8:0] out_upd_addr;
  logic       out_upd_taken, out_mispredict, out_res_err;
  logic       in_flush = 1'b0;
`ifdef BPU_UPDQ_STATS_EN
  logic [31:0] out_stat_resolved, out_stat_mispred;
`endif

  int vectors = 0;
  int errs    = 0;

  bpu_update_queue #(.ADDR_WIDTH(9), .DEPTH(8), .PTR_WIDTH(3)) dut (
    .in_Clk(in_Clk), .in_Rst(in_Rst),
    .in_pred_valid(in_pred_valid), .in_pred_addr(in_pred_addr), .in_pred_taken(in_pred_taken),
    .out_full(out_full), .out_empty(out_empty), .out_count(out_count),
    .in_res_valid(in_res_valid), .in_res_taken(in_res_taken),
    .out_upd_valid(out_upd_valid), .out_upd_addr(out_upd_addr), .out_upd_taken(out_upd_taken),
    .out_mispredict(out_mispredict), .out_res_err(out_res_err),
    .in_flush(in_flush)
`ifdef BPU_UPDQ_STATS_EN
    , .out_stat_resolved(out_stat_resolved), .out_stat_mispred(out_stat_mispred)
`endif
  );

  always #5 in_Clk = ~in_Clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, sample 1 time unit after the rising edge, then go idle.
  task automatic cyc(input logic pv, input logic [8:0] pa, input logic pt,
                     input logic rv, input logic rt, input logic fl);
    in_pred_valid = pv; in_pred_addr = pa; in_pred_taken = pt;
    in_res_valid  = rv; in_res_taken = rt; in_flush = fl;
    @(posedge in_Clk); #1;
    in_pred_valid = 1'b0; in_res_valid = 1'b0; in_flush = 1'b0;
  endtask

  task automatic push(input logic [8:0] a, input logic t);
    cyc(1'b1, a, t, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic t);
    cyc(1'b0, 9'd0, 1'b0, 1'b1, t, 1'b0);
  endtask

  initial begin
    in_Rst = 1'b1;
    #2;
    check("rst_count", 32'(out_count), 32'd0);
    check("rst_empty", 32'(out_empty), 32'd1);
    check("rst_full", 32'(out_full), 32'd0);
    check("rst_updv", 32'(out_upd_valid), 32'd0);
    check("rst_err", 32'(out_res_err), 32'd0);
    check("rst_misp", 32'(out_mispredict), 32'd0);
    #1 in_Rst = 1'b0;

    // Basic push then correct resolve
    push(9'd5, 1'b1); push(9'd9, 1'b0); push(9'd17, 1'b1);
    check("p3_count", 32'(out_count), 32'd3);
    check("p3_empty", 32'(out_empty), 32'd0);
    resolve(1'b1);
    check("r1_updv", 32'(out_upd_valid), 32'd1);
    check("r1_addr", 32'(out_upd_addr), 32'd5);
    check("r1_taken", 32'(out_upd_taken), 32'd1);
    check("r1_misp", 32'(out_mispredict), 32'd0);
    check("r1_count", 32'(out_count), 32'd2);
    cyc(1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("r1_pulse", 32'(out_upd_valid), 32'd0);
    cyc(1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("flush_count", 32'(out_count), 32'd0);
    check("flush_empty", 32'(out_empty), 32'd1);
    check("flush_updv", 32'(out_upd_valid), 32'd0);

    // Fill, overfill drop, drain in order
    for (int i = 0; i < 8; i++) push(9'(10 + i), 1'(i));
    check("fill_full", 32'(out_full), 32'd1);
    push(9'd99, 1'b1);
    check("ovf_full", 32'(out_full), 32'd1);
    check("ovf_count", 32'(out_count), 32'd8);
    for (int i = 0; i < 8; i++) begin
      resolve(1'(i));
      check("drain_addr", 32'(out_upd_addr), 32'(10 + i));
      check("drain_misp", 32'(out_mispredict), 32'd0);
    end
    check("drain_empty", 32'(out_empty), 32'd1);

    // Mispredict squashes younger entries
    for (int i = 0; i < 4; i++) push(9'(20 + i), 1'b1);
    resolve(1'b0);
    check("mp_misp", 32'(out_mispredict), 32'd1);
    check("mp_taken", 32'(out_upd_taken), 32'd0);
    check("mp_addr", 32'(out_upd_addr), 32'd20);
    check("mp_count", 32'(out_count), 32'd0);
    check("mp_empty", 32'(out_empty), 32'd1);
    cyc(1'b0, 9'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("mp_pulse", 32'(out_mispredict), 32'd0);

    // Push + resolve on a full queue
    for (int i = 0; i < 8; i++) push(9'(30 + i), 1'b1);
    cyc(1'b1, 9'd42, 1'b1, 1'b1, 1'b1, 1'b0);
    check("pr_addr", 32'(out_upd_addr), 32'd30);
    check("pr_count", 32'(out_count), 32'd8);
    for (int i = 0; i < 7; i++) begin
      resolve(1'b1);
      check("pr_drain", 32'(out_upd_addr), 32'(31 + i));
    end
    resolve(1'b1);
    check("pr_last42", 32'(out_upd_addr), 32'd42);
    check("pr_empty", 32'(out_empty), 32'd1);

    // Resolve while empty
    resolve(1'b1);
    check("re_err", 32'(out_res_err), 32'd1);
    check("re_updv", 32'(out_upd_valid), 32'd0);
    check("re_count", 32'(out_count), 32'd0);
    push(9'd50, 1'b0);
    check("re_err_pulse", 32'(out_res_err), 32'd0);
    resolve(1'b0);
    check("re_next_addr", 32'(out_upd_addr), 32'd50);
    check("re_next_misp", 32'(out_mispredict), 32'd0);

    // Push while empty with resolve: push accepted, error flagged
    cyc(1'b1, 9'd55, 1'b1, 1'b1, 1'b1, 1'b0);
    check("pe_err", 32'(out_res_err), 32'd1);
    check("pe_count", 32'(out_count), 32'd1);
    resolve(1'b1);
    check("pe_addr", 32'(out_upd_addr), 32'd55);

    // Push alongside a mispredicting resolve is dropped
    push(9'd60, 1'b1);
    cyc(1'b1, 9'd61, 1'b1, 1'b1, 1'b0, 1'b0);
    check("pm_misp", 32'(out_mispredict), 32'd1);
    check("pm_count", 32'(out_count), 32'd0);

    // Flush with same-cycle resolve still emits the update
    push(9'd70, 1'b1); push(9'd71, 1'b1);
    cyc(1'b1, 9'd72, 1'b1, 1'b1, 1'b1, 1'b1);
    check("fr_updv", 32'(out_upd_valid), 32'd1);
    check("fr_addr", 32'(out_upd_addr), 32'd70);
    check("fr_count", 32'(out_count), 32'd0);
    push(9'd73, 1'b0);
    resolve(1'b0);
    check("fr_after", 32'(out_upd_addr), 32'd73);

    // Asynchronous reset mid-cycle with 5 entries queued
    for (int i = 0; i < 6; i++) push(9'(80 + i), 1'b1);
    resolve(1'b1);
    check("ar_pre_count", 32'(out_count), 32'd5);
    check("ar_pre_updv", 32'(out_upd_valid), 32'd1);
    #2 in_Rst = 1'b1;
    #1;
    check("ar_count", 32'(out_count), 32'd0);
    check("ar_updv", 32'(out_upd_valid), 32'd0);
    check("ar_empty", 32'(out_empty), 32'd1);
`ifdef BPU_UPDQ_STATS_EN
    check("ar_stat_res", out_stat_resolved, 32'd0);
    check("ar_stat_mis", out_stat_mispred, 32'd0);
`endif
    @(negedge in_Clk) in_Rst = 1'b0;
    push(9'd90, 1'b1);
    resolve(1'b1);
    check("post_rst_addr", 32'(out_upd_addr), 32'd90);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/bpu_update_queue.md
Name: bpu_update_queue

Overview:
- Write-side companion to the pattern history table (PHT).
- At fetch, records the PHT index and predicted direction of each in-flight conditional branch in an in-order FIFO.
- At execute, branch outcomes arrive in program order. The block pops the oldest entry and produces a registered PHT update (index, actual direction) plus a misprediction pulse.
- A misprediction squashes all younger recorded predictions.

Parameters:
- ADDR_WIDTH, 9, PHT index width; matches the PHT address port.
- DEPTH, 8, maximum in-flight predicted branches; power of two, >= 2.
- PTR_WIDTH, 3, log2(DEPTH).

Ports:
- in_Clk  input  1  clock, rising edge.
- in_Rst  input  1  asynchronous active-high reset.
- in_pred_valid  input  1  record a new prediction this cycle.
- in_pred_addr  input  ADDR_WIDTH  PHT index used for the prediction.
- in_pred_taken  input  1  predicted direction (PHT out_prediction).
- out_full  output  1  queue holds DEPTH entries.
- out_empty  output  1  queue holds 0 entries.
- out_count  output  PTR_WIDTH+1  current occupancy.
- in_res_valid  input  1  oldest branch resolved this cycle.
- in_res_taken  input  1  actual direction.
- out_upd_valid  output  1  PHT update strobe.
- out_upd_addr  output  ADDR_WIDTH  PHT index to update.
- out_upd_taken  output  1  value for the PHT in_data input.
- out_mispredict  output  1  one-cycle pulse: predicted != actual.
- out_res_err  output  1  one-cycle pulse: resolve arrived while empty.
- in_flush  input  1  external pipeline flush (e.g. exception); clears the queue.

Behaviour:
- Reset (in_Rst=1, asynchronous):
  - Pointers and count go to 0; out_empty=1, out_full=0.
  - out_upd_valid, out_upd_addr, out_upd_taken, out_mispredict and out_res_err all go to 0.
  - Entry storage contents are don't-care.
  - Reset mid-operation discards all entries immediately. No update is emitted for discarded entries.
- Storage:
  - Circular buffer of DEPTH entries {addr, taken}.
  - wr_ptr and rd_ptr are PTR_WIDTH bits and wrap modulo DEPTH.
  - Count is tracked separately, PTR_WIDTH+1 bits.
- Push: on an edge with in_pred_valid=1 and not full, write the entry at wr_ptr, then wr_ptr+1 and count+1. Push while full is dropped silently; state is unchanged.
- Resolve, when in_res_valid=1 and not empty:
  - Read the entry at rd_ptr; rd_ptr+1, count-1.
  - Next cycle (1-cycle latency, registered): out_upd_valid=1, out_upd_addr=entry.addr, out_upd_taken=in_res_taken, out_mispredict=(entry.taken != in_res_taken).
- Resolve when empty: no pointer change, out_upd_valid=0, out_res_err=1 for one cycle.
- Mispredict squash: if the resolve mispredicts, all younger entries are discarded in the same edge. Result: wr_ptr=rd_ptr_next, count=0. The update for the resolved branch is still emitted.
- Simultaneous push + resolve, no mispredict: both take effect and count is unchanged.
  - Legal when full: the pop frees a slot in the same edge, so the push is accepted.
  - When empty, the push is accepted and the resolve flags out_res_err; same-cycle bypass is not supported.
- Simultaneous push + mispredicting resolve: the squash wins and the push is dropped. The pushed branch is wrong-path by definition.
- in_flush=1:
  - Clears the queue (pointers equal, count=0); overrides push.
  - A resolve in the same cycle is still processed first and its update emitted, because the resolved branch is older than the flush cause.
- Outputs are registered; out_upd_valid and out_mispredict are single-cycle pulses.
- out_full and out_empty are decoded combinationally from the registered count.

Optional Feature:
- Macro: BPU_UPDQ_STATS_EN.
- Defined:
  - Adds outputs out_stat_resolved[31:0] and out_stat_mispred[31:0].
  - Counters increment on each successful resolve and each misprediction respectively.
  - Both saturate at 32'hFFFFFFFF and reset to 0.
  - Not cleared by in_flush.
- Undefined: neither port nor counters exist; behaviour is otherwise identical.

Test Plan:
- Reset then push 3 entries (addr 5/T, 9/N, 17/T), no resolve.
  - Required: out_count=3, out_empty=0.
  - Resolve taken=1: next cycle out_upd_valid=1, out_upd_addr=5, out_upd_taken=1, out_mispredict=0, out_count=2.
- Fill 8 entries, then push a 9th (addr 99).
  - Required: dropped, out_full=1, out_count=8.
  - Resolve 8 times: addresses emerge in push order, never 99.
- With 4 entries queued, resolve the oldest (pred T) with taken=0.
  - Required: next cycle out_mispredict=1, out_upd_taken=0; out_count=0, out_empty=1.
- Full queue, push addr 42 and resolve (correct) in the same cycle.
  - Required: out_count stays 8; after 7 more resolves, addr 42 emerges last.
- Resolve on an empty queue.
  - Required: out_res_err=1 for one cycle, out_upd_valid=0, pointers unchanged.
- Assert in_Rst asynchronously between edges with 5 entries queued.
  - Required: out_count=0 and out_upd_valid=0 immediately.
  - With BPU_UPDQ_STATS_EN defined: stats counters read 0.
